// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: control, load and status bundle for the BCD up/down counter
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2
);
  logic                en;
  logic                up;
  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd;
  logic                tc;
  logic                load_err;
  modport master (
    output en, up, clear, load, load_val,
    input  bcd, tc, load_err
  );
  modport slave (
    input  en, up, clear, load, load_val,
    output bcd, tc, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with clear, checked load, wrap or saturate
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter bit SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  bcd_updown_counter_if.slave  bus
);
  localparam int W = 4 * DIGITS;
  logic [W-1:0] bcd_q, inc, dec, nxt;
  logic         tc_q, err_q, limit, load_ok;
  // full ripple of carry/borrow in one cycle; c/b end high only when every digit is at the limit
  always_comb begin : step_logic
    logic       c, b, ok;
    logic [3:0] d;
    inc = bcd_q;
    dec = bcd_q;
    c   = 1'b1;
    b   = 1'b1;
    ok  = 1'b1;
    d   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d              = bcd_q[4*i +: 4];
      inc[4*i +: 4]  = c ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
      dec[4*i +: 4]  = b ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
      c              = c & (d == 4'd9);
      b              = b & (d == 4'd0);
      ok             = ok & (bus.load_val[4*i +: 4] <= 4'd9);
    end
    limit   = bus.up ? c : b;
    load_ok = ok;
  end
  assign nxt = bus.up ? inc : dec;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.clear) begin
      bcd_q <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.load) begin
      bcd_q <= load_ok ? bus.load_val : bcd_q;
      tc_q  <= 1'b0;
      err_q <= ~load_ok;
    end else begin
      bcd_q <= (bus.en && !(SATURATE && limit)) ? nxt : bcd_q;
      tc_q  <= bus.en & limit;
      err_q <= 1'b0;
    end
  end
  assign bus.bcd      = bcd_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed vectors with a per-DUT expectation queue drained by a negedge monitor
module tb_bcd_updown_counter;
  typedef struct {
    logic [15:0] bcd;
    logic        tc;
    logic        err;
    string       name;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  bcd_updown_counter_if #(.DIGITS(2)) if0 ();
  bcd_updown_counter_if #(.DIGITS(2)) if1 ();
  bcd_updown_counter_if #(.DIGITS(4)) if2 ();
  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  task automatic cmp(input string nm, input logic [15:0] ab, input logic at, input logic ae,
                     input logic [15:0] eb, input logic et, input logic ee);
    n_vec++;
    if (ab !== eb || at !== et || ae !== ee) begin
      n_bad++;
      $display("FAIL %s: got bcd=%h tc=%b load_err=%b, want bcd=%h tc=%b load_err=%b",
               nm, ab, at, ae, eb, et, ee);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp(e.name, {8'h00, if0.bcd}, if0.tc, if0.load_err, e.bcd, e.tc, e.err);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp(e.name, {8'h00, if1.bcd}, if1.tc, if1.load_err, e.bcd, e.tc, e.err);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      cmp(e.name, if2.bcd, if2.tc, if2.load_err, e.bcd, e.tc, e.err);
    end
  end

  function automatic logic [15:0] bcd2(input int n);
    return 16'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic idle_all();
    {if0.en, if0.up, if0.clear, if0.load} = 4'b0;
    {if1.en, if1.up, if1.clear, if1.load} = 4'b0;
    {if2.en, if2.up, if2.clear, if2.load} = 4'b0;
    if0.load_val = '0;
    if1.load_val = '0;
    if2.load_val = '0;
  endtask

  task automatic step(input int id, input logic en, input logic up, input logic clr, input logic ld,
                      input logic [15:0] lv, input logic [15:0] eb, input logic et, input logic ee,
                      input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    idle_all();
    e.bcd = eb; e.tc = et; e.err = ee; e.name = nm;
    case (id)
      0: begin {if0.en, if0.up, if0.clear, if0.load} = {en, up, clr, ld}; if0.load_val = lv[7:0]; q0.push_back(e); end
      1: begin {if1.en, if1.up, if1.clear, if1.load} = {en, up, clr, ld}; if1.load_val = lv[7:0]; q1.push_back(e); end
      default: begin {if2.en, if2.up, if2.clear, if2.load} = {en, up, clr, ld}; if2.load_val = lv; q2.push_back(e); end
    endcase
  endtask

  initial begin
    idle_all();
    #2;
    cmp("reset_d0", {8'h00, if0.bcd}, if0.tc, if0.load_err, 16'h0, 1'b0, 1'b0);
    cmp("reset_d1", {8'h00, if1.bcd}, if1.tc, if1.load_err, 16'h0, 1'b0, 1'b0);
    cmp("reset_d2", if2.bcd, if2.tc, if2.load_err, 16'h0, 1'b0, 1'b0);
    #13 reset = 1'b0;
    // wrap counter: 100 increments, single tc on 99->00
    for (int i = 0; i < 100; i++)
      step(0, 1, 1, 0, 0, 16'h0, bcd2((i + 1) % 100), i == 99, 0, "inc_sweep");
    step(0, 0, 0, 0, 1, 16'h47, 16'h47, 0, 0, "load_47");
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, 0, 16'h0, bcd2(46 - i), 0, 0, "dec_borrow");
    step(0, 0, 0, 0, 1, 16'h01, 16'h01, 0, 0, "load_01");
    step(0, 1, 0, 0, 0, 16'h0, 16'h00, 0, 0, "dec_to_00");
    step(0, 1, 0, 0, 0, 16'h0, 16'h99, 1, 0, "dec_wrap");
    step(0, 0, 0, 0, 0, 16'h0, 16'h99, 0, 0, "hold");
    step(0, 1, 1, 0, 1, 16'h4A, 16'h99, 0, 1, "load_bad");
    step(0, 0, 0, 0, 0, 16'h0, 16'h99, 0, 0, "err_one_cycle");
    step(0, 1, 1, 1, 1, 16'h4A, 16'h00, 0, 0, "clear_over_load");
    step(0, 1, 1, 0, 1, 16'h05, 16'h05, 0, 0, "load_beats_en");
    step(0, 1, 0, 0, 0, 16'h0, 16'h04, 0, 0, "toggle_down");
    step(0, 1, 1, 0, 0, 16'h0, 16'h05, 0, 0, "toggle_up");
    step(0, 0, 0, 0, 1, 16'h57, 16'h57, 0, 0, "load_57");
    // async reset between edges
    @(negedge clk);
    idle_all();
    #3 reset = 1'b1;
    #1 cmp("async_reset", {8'h00, if0.bcd}, if0.tc, if0.load_err, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    step(0, 1, 1, 0, 0, 16'h0, 16'h01, 0, 0, "resume_01");
    step(0, 1, 1, 0, 0, 16'h0, 16'h02, 0, 0, "resume_02");
    // saturating counter
    step(1, 0, 0, 0, 1, 16'h98, 16'h98, 0, 0, "sat_load_98");
    step(1, 1, 1, 0, 0, 16'h0, 16'h99, 0, 0, "sat_inc1");
    step(1, 1, 1, 0, 0, 16'h0, 16'h99, 1, 0, "sat_inc2");
    step(1, 1, 1, 0, 0, 16'h0, 16'h99, 1, 0, "sat_inc3");
    step(1, 0, 0, 1, 0, 16'h0, 16'h00, 0, 0, "sat_clear");
    step(1, 1, 0, 0, 0, 16'h0, 16'h00, 1, 0, "sat_dec_hold");
    step(1, 1, 0, 0, 0, 16'h0, 16'h00, 1, 0, "sat_dec_hold2");
    step(1, 1, 1, 0, 0, 16'h0, 16'h01, 0, 0, "sat_inc_free");
    // four digits: full ripple
    step(2, 0, 0, 0, 1, 16'h9999, 16'h9999, 0, 0, "d4_load_9999");
    step(2, 1, 1, 0, 0, 16'h0, 16'h0000, 1, 0, "d4_inc_wrap");
    step(2, 1, 0, 0, 0, 16'h0, 16'h9999, 1, 0, "d4_dec_wrap");
    step(2, 0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, "d4_load_1000");
    step(2, 1, 0, 0, 0, 16'h0, 16'h0999, 0, 0, "d4_dec_ripple");
    step(2, 0, 0, 0, 1, 16'h09A0, 16'h0999, 0, 1, "d4_load_bad");
    @(negedge clk);
    #1 idle_all();
    @(negedge clk);
    @(negedge clk);
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of BCD digits (legal range 1..8).
REQ-002 SHALL have parameter SATURATE, default 0, overflow mode: 0 = wrap, 1 = hold at the limit.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable, one step per clock while high.
REQ-006 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port clear  input  1  synchronous clear to zero.
REQ-008 SHALL have port load  input  1  synchronous parallel load request.
REQ-009 SHALL have port load_val  input  4*DIGITS  packed BCD load value; digit 0 (LSB) is in bits [3:0].
REQ-010 SHALL have port bcd  output  4*DIGITS  packed BCD count; same packing as load_val.
REQ-011 SHALL have port tc  output  1  registered one-cycle pulse on a wrap or saturation event.
REQ-012 SHALL have port load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-013 Each digit of bcd SHALL hold a value in the range 0..9 at all times.
REQ-014 Per-edge priority SHALL be: clear, then load, then count (en).
REQ-015 When clear=1, bcd SHALL become 0 on the next edge, tc=0 and load_err=0, regardless of load and en.
REQ-016 On a load with every load_val digit <= 9, bcd SHALL take load_val on the next edge and no count step SHALL occur that cycle.
REQ-017 On a load with any load_val digit > 9:
- bcd SHALL be left unchanged (no count step that cycle);
- load_err SHALL pulse high for exactly one cycle.
REQ-018 When en=1 and up=1 (no clear or load), the increment SHALL behave as follows:
- digit 0 increments;
- a digit at 9 goes to 0 and carries into the next digit;
- ripple resolves within one cycle (latency 1 clock).
REQ-019 When en=1 and up=0, the decrement SHALL behave as follows:
- digit 0 decrements;
- a digit at 0 goes to 9 and borrows from the next digit;
- latency is 1 clock.
REQ-020 The upper limit SHALL be all digits 9 (10^DIGITS - 1) and the lower limit SHALL be 0.
REQ-021 With SATURATE=0, incrementing at the upper limit SHALL wrap bcd to 0 and decrementing at 0 SHALL wrap bcd to the upper limit, and tc SHALL pulse on the same edge.
REQ-022 With SATURATE=1, counting past either limit SHALL hold bcd at that limit and tc SHALL pulse on every such attempted step.
REQ-023 tc and load_err SHALL be 0 in every cycle without their event.
REQ-024 With en=0, clear=0 and load=0, bcd SHALL hold its value.
REQ-025 Toggling up SHALL take effect on the next enabled edge, with no lost or double step.

Reset
REQ-026 When reset is asserted, bcd, tc and load_err SHALL go to 0 immediately, without waiting for a clock edge.
REQ-027 While reset is high, all other inputs SHALL be ignored.
REQ-028 Counting SHALL resume from 0 at the first rising edge after reset deasserts.
REQ-029 Reset asserted in the middle of a count SHALL abort that count without leaving a partial-carry state.

Verification (DIGITS=2 unless stated)
REQ-030 Reset for 15 ns, then en=1, up=1 for 100 clocks SHALL give:
- bcd 00->01->...->09->10->...->99->00;
- a single tc pulse on the 99->00 edge.
REQ-031 Loading 0x47 and then counting down SHALL give 47->46->...->40->39 (borrow), and from 00 SHALL wrap to 99 with a tc pulse.
REQ-032 Loading 0x4A SHALL give load_err=1 for one cycle with bcd unchanged; the same cycle with clear=1 SHALL give bcd=00 and no load_err.
REQ-033 With SATURATE=1, loading 98 and incrementing three times SHALL give bcd 99, 99, 99 with tc pulsing on the 2nd and 3rd clocks; at 00, a decrement SHALL hold 00 and pulse tc.
REQ-034 Asserting reset asynchronously between edges while bcd=57 SHALL clear bcd to 00 before the next edge, and the count SHALL resume 01, 02... after release.
REQ-035 With DIGITS=4, loading 9999 and incrementing once SHALL give 0000 with tc=1, exercising the full carry ripple.
